// File: rtl/sdot_sequencer.sv
// sdot_sequencer: CSR-controlled dot-product sequencer.
// Fetches X[i] and Y[i] pairs from an external operand buffer. It steps them through
// an external FP multiplier and adder, and posts the accumulated result in RESULT.
// No arithmetic on data words happens here; the block only routes and sequences them.
module sdot_sequencer #(
    parameter int unsigned ADDR_W    = 32'd8,
    parameter int unsigned LEN_RST   = 32'd96,
    parameter int unsigned YBASE_RST = 32'd96
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    input  logic [31:0]       writedata,
    input  logic              write,
    input  logic              read,
    input  logic              chipselect,
    output logic [31:0]       readdata,
    output logic              waitrequest,
    output logic [ADDR_W-1:0] op_addr,
    output logic              op_rd,
    input  logic [31:0]       op_rdata,
    output logic [31:0]       dp_a,
    output logic [31:0]       dp_b,
    input  logic [31:0]       dp_product,
    output logic [31:0]       dp_acc,
    output logic [31:0]       dp_addend,
    input  logic [31:0]       dp_sum,
    output logic              irq
);

    localparam logic [ADDR_W-1:0] A_CTRL   = ADDR_W'(32'd0);
    localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(32'd1);
    localparam logic [ADDR_W-1:0] A_LEN    = ADDR_W'(32'd2);
    localparam logic [ADDR_W-1:0] A_XBASE  = ADDR_W'(32'd3);
    localparam logic [ADDR_W-1:0] A_YBASE  = ADDR_W'(32'd4);
    localparam logic [ADDR_W-1:0] A_RESULT = ADDR_W'(32'd5);
    localparam logic [ADDR_W-1:0] A_COUNT  = ADDR_W'(32'd6);
    localparam logic [ADDR_W-1:0] ONE_A    = ADDR_W'(32'd1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RDX  = 3'd1,
        S_RDY  = 3'd2,
        S_MUL  = 3'd3,
        S_ADD  = 3'd4,
        S_ACC  = 3'd5,
        S_DONE = 3'd6
    } state_t;

    state_t            state_r;
    logic              ie_r, done_r, err_r, irq_r;
    logic [ADDR_W-1:0] len_r, xbase_r, ybase_r, count_r, op_addr_r;
    logic              op_rd_r;
    logic [31:0]       result_r, dp_a_r, dp_b_r, dp_acc_r, dp_addend_r;
    logic [31:0]       readdata_r;
    logic              rd_ack_r;

    logic              wr_s, rd_s, busy_s, ctrl_wr_s, cfg_wr_s;
    logic              start_s, abort_run_s, go_run_s, zero_run_s;
    logic              last_s, finish_s;
    logic [2:0]        w1c_s;
    logic              done_n_s, err_n_s, ie_n_s;
    logic [ADDR_W-1:0] count_inc_s;
    logic [31:0]       rd_data_s;
    logic              wdata_unused_s;

    // Upper write-data bits are never stored by any register.
    assign wdata_unused_s = ^writedata[31:ADDR_W];

    // Decode bus writes into control events and next values of the status bits.
    always_comb begin
        wr_s        = chipselect & write;
        rd_s        = chipselect & read;
        busy_s      = (state_r != S_IDLE);
        ctrl_wr_s   = wr_s && (address == A_CTRL);
        cfg_wr_s    = wr_s && ((address == A_LEN) || (address == A_XBASE) ||
                               (address == A_YBASE));
        // Abort in the same write as start wins, so such a write is never a start.
        start_s     = ctrl_wr_s & writedata[0] & ~writedata[1];
        abort_run_s = ctrl_wr_s & writedata[1] & busy_s;
        go_run_s    = start_s & ~busy_s & (len_r != '0);
        zero_run_s  = start_s & ~busy_s & (len_r == '0);
        count_inc_s = count_r + ONE_A;
        last_s      = (state_r == S_ACC) && (count_inc_s == len_r);
        finish_s    = last_s & ~abort_run_s;
        w1c_s       = (wr_s && (address == A_STATUS)) ? writedata[2:0] : 3'b000;
        done_n_s    = (zero_run_s | finish_s) ? 1'b1 :
                      ((go_run_s | w1c_s[1]) ? 1'b0 : done_r);
        err_n_s     = (zero_run_s | (start_s & busy_s) | (cfg_wr_s & busy_s)) ? 1'b1 :
                      ((go_run_s | w1c_s[2]) ? 1'b0 : err_r);
        ie_n_s      = ctrl_wr_s ? writedata[2] : ie_r;
    end

    // CSR read multiplexer; undecoded addresses read as zero.
    always_comb begin
        rd_data_s = 32'd0;
        case (address)
            A_CTRL:   rd_data_s = {29'd0, ie_r, 2'b00};
            A_STATUS: rd_data_s = {29'd0, err_r, done_r, busy_s};
            A_LEN:    rd_data_s = 32'(len_r);
            A_XBASE:  rd_data_s = 32'(xbase_r);
            A_YBASE:  rd_data_s = 32'(ybase_r);
            A_RESULT: rd_data_s = result_r;
            A_COUNT:  rd_data_s = 32'(count_r);
            default:  rd_data_s = 32'd0;
        endcase
    end

    // Status bits and interrupt; irq is registered from the next-state values so it tracks done exactly.
    always_ff @(posedge clk) begin
        if (reset) begin
            ie_r   <= 1'b0;
            done_r <= 1'b0;
            err_r  <= 1'b0;
            irq_r  <= 1'b0;
        end else begin
            ie_r   <= ie_n_s;
            done_r <= done_n_s;
            err_r  <= err_n_s;
            irq_r  <= done_n_s & ie_n_s;
        end
    end

    // Run configuration; frozen while a run is in progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            len_r   <= ADDR_W'(LEN_RST);
            xbase_r <= '0;
            ybase_r <= ADDR_W'(YBASE_RST);
        end else if (cfg_wr_s && !busy_s) begin
            case (address)
                A_LEN:   len_r   <= writedata[ADDR_W-1:0];
                A_XBASE: xbase_r <= writedata[ADDR_W-1:0];
                A_YBASE: ybase_r <= writedata[ADDR_W-1:0];
                default: len_r   <= len_r;
            endcase
        end
    end

    // Sequencer FSM: five states per element, with all buffer and datapath outputs registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= S_IDLE;
            count_r     <= '0;
            result_r    <= 32'd0;
            op_addr_r   <= '0;
            op_rd_r     <= 1'b0;
            dp_a_r      <= 32'd0;
            dp_b_r      <= 32'd0;
            dp_acc_r    <= 32'd0;
            dp_addend_r <= 32'd0;
        end else if (abort_run_s) begin
            state_r <= S_IDLE;
            op_rd_r <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (go_run_s) begin
                        state_r   <= S_RDX;
                        count_r   <= '0;
                        dp_acc_r  <= 32'd0;
                        op_rd_r   <= 1'b1;
                        op_addr_r <= xbase_r;
                    end else if (zero_run_s) begin
                        result_r <= 32'd0;
                    end else begin
                        op_rd_r <= 1'b0;
                    end
                end
                S_RDX: begin
                    state_r   <= S_RDY;
                    op_rd_r   <= 1'b1;
                    op_addr_r <= ybase_r + count_r;
                end
                S_RDY: begin
                    state_r <= S_MUL;
                    op_rd_r <= 1'b0;
                    dp_a_r  <= op_rdata;
                end
                S_MUL: begin
                    state_r <= S_ADD;
                    dp_b_r  <= op_rdata;
                end
                S_ADD: begin
                    state_r     <= S_ACC;
                    dp_addend_r <= dp_product;
                end
                S_ACC: begin
                    dp_acc_r <= dp_sum;
                    count_r  <= count_inc_s;
                    if (finish_s) begin
                        // RESULT and done are posted on entry to DONE so both are visible in the DONE cycle.
                        state_r  <= S_DONE;
                        result_r <= dp_sum;
                    end else begin
                        state_r   <= S_RDX;
                        op_rd_r   <= 1'b1;
                        op_addr_r <= xbase_r + count_inc_s;
                    end
                end
                S_DONE: begin
                    state_r  <= S_IDLE;
                    result_r <= dp_acc_r;
                end
                default: begin
                    state_r <= S_IDLE;
                    op_rd_r <= 1'b0;
                end
            endcase
        end
    end

    // Two-cycle read handshake: the first cycle stalls and captures the data, the second cycle presents it.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ack_r   <= 1'b0;
            readdata_r <= 32'd0;
        end else begin
            rd_ack_r <= rd_s & ~rd_ack_r;
            if (rd_s && !rd_ack_r) begin
                readdata_r <= rd_data_s;
            end
        end
    end

    assign waitrequest = rd_s & ~rd_ack_r;
    assign readdata    = readdata_r;
    assign op_addr     = op_addr_r;
    assign op_rd       = op_rd_r;
    assign dp_a        = dp_a_r;
    assign dp_b        = dp_b_r;
    assign dp_acc      = dp_acc_r;
    assign dp_addend   = dp_addend_r;
    assign irq         = irq_r;

endmodule

// File: tb/tb_sdot_sequencer.sv
// Self-checking bench for sdot_sequencer. It provides an operand memory and a
// combinational datapath (float32 for the directed FP case, integer otherwise).
// A reference model computes the expected results from the buffer contents.
module tb_sdot_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  address;
    logic [31:0] writedata;
    logic        write, read, chipselect;
    logic [31:0] readdata;
    logic        waitrequest;
    logic [7:0]  op_addr;
    logic        op_rd;
    logic [31:0] op_rdata = 32'd0;
    logic [31:0] dp_a, dp_b, dp_product, dp_acc, dp_addend, dp_sum;
    logic        irq;

    logic [31:0] mem [0:255];
    logic [7:0]  addr_q [$];
    bit          fp_mode = 1'b0;
    int          passed = 0;
    int          total  = 0;
    logic [31:0] last_result;

    typedef struct {
        logic        do_wr;
        logic [7:0]  wa;
        logic [31:0] wd;
        logic [7:0]  ra;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs [10];

    always #5 clk = ~clk;

    sdot_sequencer dut (
        .clk(clk), .reset(reset), .address(address), .writedata(writedata),
        .write(write), .read(read), .chipselect(chipselect), .readdata(readdata),
        .waitrequest(waitrequest), .op_addr(op_addr), .op_rd(op_rd),
        .op_rdata(op_rdata), .dp_a(dp_a), .dp_b(dp_b), .dp_product(dp_product),
        .dp_acc(dp_acc), .dp_addend(dp_addend), .dp_sum(dp_sum), .irq(irq)
    );

    // Operand buffer: data appears one cycle after the read strobe.
    always @(posedge clk) begin
        if (op_rd) op_rdata <= mem[op_addr];
    end

    // Record every buffer address presented with a read strobe.
    always @(negedge clk) begin
        if (op_rd === 1'b1) addr_q.push_back(op_addr);
    end

    function automatic real f2r(input logic [31:0] b);
        real r;
        int  e;
        if (b[30:0] == 31'd0) return 0.0;
        r = 1.0 + real'(b[22:0]) / 8388608.0;
        e = int'(b[30:23]) - 127;
        for (int k = 0; k < 256; k++) begin
            if (e > 0) begin r = r * 2.0; e--; end
            else if (e < 0) begin r = r / 2.0; e++; end
        end
        return b[31] ? -r : r;
    endfunction

    function automatic logic [31:0] r2f(input real v);
        logic        s;
        real         a;
        int          e;
        logic [31:0] m;
        if (v == 0.0) return 32'd0;
        s = (v < 0.0);
        a = s ? -v : v;
        e = 127;
        for (int k = 0; k < 300; k++) begin
            if (a >= 2.0) begin a = a / 2.0; e++; end
            else if (a < 1.0) begin a = a * 2.0; e--; end
        end
        m = 32'($rtoi((a - 1.0) * 8388608.0));
        return {s, 8'(e), m[22:0]};
    endfunction

    // External datapath stand-in.
    always_comb begin
        if (fp_mode) begin
            dp_product = r2f(f2r(dp_a) * f2r(dp_b));
            dp_sum     = r2f(f2r(dp_acc) + f2r(dp_addend));
        end else begin
            dp_product = dp_a * dp_b;
            dp_sum     = dp_acc + dp_addend;
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    endtask

    task automatic csr_write(input logic [7:0] a, input logic [31:0] d);
        address = a; writedata = d; write = 1'b1; chipselect = 1'b1;
        @(negedge clk);
        write = 1'b0; chipselect = 1'b0;
    endtask

    task automatic csr_read(input logic [7:0] a, output logic [31:0] d);
        address = a; read = 1'b1; chipselect = 1'b1;
        #1;
        check("waitrequest_first", 32'(waitrequest), 32'd1);
        @(negedge clk);
        check("waitrequest_second", 32'(waitrequest), 32'd0);
        d = readdata;
        read = 1'b0; chipselect = 1'b0;
        @(negedge clk);
    endtask

    // Cycles since the start-write cycle until irq is seen (n=1 is the cycle after the write).
    task automatic wait_irq(output int n);
        n = 1;
        while (irq !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
    endtask

    // Reference: sum over i of X[xb+i]*Y[yb+i], addresses modulo 256, 32-bit wrap.
    function automatic logic [31:0] model_sum(input int len, input logic [7:0] xb, input logic [7:0] yb);
        logic [31:0] s = 32'd0;
        for (int i = 0; i < len; i++) s = s + mem[8'(xb + 8'(i))] * mem[8'(yb + 8'(i))];
        return s;
    endfunction

    task automatic run_int(input int len, input logic [7:0] xb, input logic [7:0] yb, input string tag);
        logic [31:0] exp_sum, rd;
        logic [7:0]  exp_q [$];
        int          n, mism;
        for (int k = 0; k < 256; k++) mem[k] = $urandom;
        csr_write(8'd2, 32'(len));
        csr_write(8'd3, 32'(xb));
        csr_write(8'd4, 32'(yb));
        exp_sum = model_sum(len, xb, yb);
        for (int i = 0; i < len; i++) begin
            exp_q.push_back(8'(xb + 8'(i)));
            exp_q.push_back(8'(yb + 8'(i)));
        end
        addr_q.delete();
        csr_write(8'd0, 32'h5);
        wait_irq(n);
        check({tag, "_latency"}, 32'(n), 32'(5 * len + 1));
        csr_read(8'd5, rd);
        check({tag, "_result"}, rd, exp_sum);
        csr_read(8'd6, rd);
        check({tag, "_count"}, rd, 32'(len));
        csr_read(8'd1, rd);
        check({tag, "_status"}, rd, 32'd2);
        check({tag, "_nreads"}, 32'(addr_q.size()), 32'(exp_q.size()));
        mism = 0;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i >= addr_q.size()) mism++;
            else if (addr_q[i] !== exp_q[i]) mism++;
        end
        check({tag, "_addrseq"}, 32'(mism), 32'd0);
        csr_write(8'd1, 32'h2);
        check({tag, "_irq_clr"}, 32'(irq), 32'd0);
        last_result = exp_sum;
    endtask

    initial begin
        logic [31:0] rd;
        int          n, hits;
        logic [7:0]  seq039 [8];

        reset = 1'b1; address = 8'd0; writedata = 32'd0;
        write = 1'b0; read = 1'b0; chipselect = 1'b0;
        for (int k = 0; k < 256; k++) mem[k] = 32'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Reset state of outputs and registers.
        check("rst_readdata", readdata, 32'd0);
        check("rst_waitrequest", 32'(waitrequest), 32'd0);
        check("rst_op_rd", 32'(op_rd), 32'd0);
        check("rst_op_addr", 32'(op_addr), 32'd0);
        check("rst_dp_a", dp_a, 32'd0);
        check("rst_dp_acc", dp_acc, 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        csr_read(8'd1, rd); check("rst_status", rd, 32'd0);
        csr_read(8'd2, rd); check("rst_len", rd, 32'd96);
        csr_read(8'd3, rd); check("rst_xbase", rd, 32'd0);
        csr_read(8'd4, rd); check("rst_ybase", rd, 32'd96);
        csr_read(8'd5, rd); check("rst_result", rd, 32'd0);
        csr_read(8'd6, rd); check("rst_count", rd, 32'd0);

        // CSR access table (idle block).
        vecs[0] = '{1'b1, 8'd2,   32'd5,         8'd2,   32'd5};
        vecs[1] = '{1'b1, 8'd3,   32'h1FF,       8'd3,   32'hFF};
        vecs[2] = '{1'b1, 8'd4,   32'h12345633,  8'd4,   32'h33};
        vecs[3] = '{1'b1, 8'd7,   32'hDEADBEEF,  8'd7,   32'd0};
        vecs[4] = '{1'b1, 8'd0,   32'h4,         8'd0,   32'h4};
        vecs[5] = '{1'b1, 8'd0,   32'h0,         8'd0,   32'h0};
        vecs[6] = '{1'b1, 8'd1,   32'h7,         8'd1,   32'h0};
        vecs[7] = '{1'b1, 8'd0,   32'h2,         8'd1,   32'h0};
        vecs[8] = '{1'b0, 8'd0,   32'h0,         8'd255, 32'h0};
        vecs[9] = '{1'b1, 8'd0,   32'h3,         8'd1,   32'h0};
        addr_q.delete();
        for (int v = 0; v < 10; v++) begin
            if (vecs[v].do_wr) csr_write(vecs[v].wa, vecs[v].wd);
            csr_read(vecs[v].ra, rd);
            check($sformatf("csr_vec%0d", v), rd, vecs[v].exp);
        end
        repeat (5) @(negedge clk);
        check("idle_abort_no_reads", 32'(addr_q.size()), 32'd0);

        // FP dot product: four of 1.0*2.0 gives 8.0.
        fp_mode = 1'b1;
        for (int k = 0; k < 4; k++) begin
            mem[k] = 32'h3F800000;
            mem[96 + k] = 32'h40000000;
        end
        csr_write(8'd2, 32'd4);
        csr_write(8'd3, 32'd0);
        csr_write(8'd4, 32'd96);
        csr_write(8'd0, 32'h5);
        wait_irq(n);
        check("fp_done_latency", 32'(n), 32'd21);
        csr_read(8'd5, rd); check("fp_result", rd, 32'h41000000);
        csr_read(8'd6, rd); check("fp_count", rd, 32'd4);
        csr_read(8'd1, rd); check("fp_status", rd, 32'd2);
        csr_write(8'd1, 32'h2);
        check("fp_irq_cleared", 32'(irq), 32'd0);
        fp_mode = 1'b0;

        // Zero-length start.
        csr_write(8'd2, 32'd0);
        addr_q.delete();
        csr_write(8'd0, 32'h5);
        repeat (10) @(negedge clk);
        check("len0_no_reads", 32'(addr_q.size()), 32'd0);
        check("len0_irq", 32'(irq), 32'd1);
        csr_read(8'd1, rd); check("len0_status", rd, 32'd6);
        csr_read(8'd5, rd); check("len0_result", rd, 32'd0);
        csr_write(8'd1, 32'h6);
        csr_read(8'd1, rd); check("len0_w1c", rd, 32'd0);

        // Address wrap.
        run_int(4, 8'd254, 8'd0, "wrap");
        seq039 = '{8'd254, 8'd0, 8'd255, 8'd1, 8'd0, 8'd2, 8'd1, 8'd3};
        hits = 0;
        for (int i = 0; i < 8; i++) if (i < addr_q.size() && addr_q[i] === seq039[i]) hits++;
        check("wrap_exact_seq", 32'(hits), 32'd8);

        // Abort seven cycles into a LEN=4 run.
        csr_write(8'd3, 32'd0);
        csr_write(8'd4, 32'd96);
        addr_q.delete();
        csr_write(8'd0, 32'h1);
        repeat (6) @(negedge clk);
        csr_write(8'd0, 32'h2);
        check("abort_op_rd", 32'(op_rd), 32'd0);
        csr_read(8'd1, rd); check("abort_status", rd, 32'd0);
        csr_read(8'd6, rd); check("abort_count", rd, 32'd1);
        csr_read(8'd5, rd); check("abort_result", rd, last_result);
        repeat (20) @(negedge clk);
        check("abort_nreads", 32'(addr_q.size()), 32'd4);

        // Writes while busy are ignored and flag err.
        for (int k = 0; k < 256; k++) mem[k] = $urandom;
        csr_write(8'd2, 32'd4);
        csr_write(8'd3, 32'd10);
        csr_write(8'd4, 32'd20);
        csr_write(8'd0, 32'h5);
        csr_write(8'd2, 32'd9);
        csr_write(8'd0, 32'h5);
        wait_irq(n);
        check("busy_latency", 32'(n), 32'd19);
        csr_read(8'd5, rd); check("busy_result", rd, model_sum(4, 8'd10, 8'd20));
        csr_read(8'd1, rd); check("busy_status", rd, 32'd6);
        csr_read(8'd2, rd); check("busy_len", rd, 32'd4);
        csr_write(8'd1, 32'h6);

        // Randomized runs against the model.
        for (int r = 0; r < 12; r++) begin
            run_int(int'($urandom_range(1, 10)), 8'($urandom_range(0, 255)),
                    8'($urandom_range(0, 255)), $sformatf("rnd%0d", r));
        end

        // Reset mid-run with a simultaneous LEN write.
        csr_write(8'd2, 32'd6);
        csr_write(8'd0, 32'h5);
        repeat (8) @(negedge clk);
        reset = 1'b1; address = 8'd2; writedata = 32'd7; write = 1'b1; chipselect = 1'b1;
        @(negedge clk);
        reset = 1'b0; write = 1'b0; chipselect = 1'b0;
        check("mrst_op_rd", 32'(op_rd), 32'd0);
        check("mrst_dp_b", dp_b, 32'd0);
        hits = 0;
        for (int c = 0; c < 40; c++) begin
            if (irq === 1'b1) hits++;
            @(negedge clk);
        end
        check("mrst_no_irq", 32'(hits), 32'd0);
        csr_read(8'd1, rd); check("mrst_status", rd, 32'd0);
        csr_read(8'd2, rd); check("mrst_len", rd, 32'd96);
        csr_read(8'd4, rd); check("mrst_ybase", rd, 32'd96);
        csr_read(8'd5, rd); check("mrst_result", rd, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
